// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, one-entry hold buffer and HALT detection.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module if_fetch_stage #(
    parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_in,
    input  logic [31:0] npc_in,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic        fetch_done,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        iren_s;
    logic        fetch_done_s;
    logic        load_fetch_s;
    logic        load_hold_s;
    logic        capture_s;
    logic [31:0] hold_instr_r;
    logic [31:0] hold_pc_r;
    logic [31:0] hold_npc_r;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_npc_r;
    logic        ifid_valid_r;

    function automatic logic is_halt(input logic [31:0] instr);
        return (instr[31:26] == HALT_OPCODE);
    endfunction

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection; flush overrides everything
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (flush) begin
                    state_next_s = ST_FETCH;
                end else if (ihit && stall) begin
                    state_next_s = ST_HOLD;
                end else if (ihit && is_halt(iload)) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_next_s = ST_FETCH;
                end else if (!stall) begin
                    state_next_s = is_halt(hold_instr_r) ? ST_HALTED : ST_FETCH;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_HALTED: begin
                if (flush) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HALTED;
                end
            end
            default: state_next_s = ST_FETCH;
        endcase
    end

    // Request, handshake and IF/ID load strobes
    always_comb begin
        iren_s       = 1'b0;
        fetch_done_s = 1'b0;
        load_fetch_s = 1'b0;
        load_hold_s  = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                iren_s       = !RST;
                fetch_done_s = ihit && !flush;
                load_fetch_s = ihit && !flush && !stall;
                capture_s    = ihit && !flush && stall;
            end
            ST_HOLD: begin
                load_hold_s = !flush && !stall;
            end
            ST_HALTED: begin
                iren_s = 1'b0;
            end
            default: begin
                iren_s = 1'b0;
            end
        endcase
    end

    // Hold buffer keeps a hit that arrived while decode was stalled
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            hold_instr_r <= BUBBLE_INSTR;
            hold_pc_r    <= 32'h0000_0000;
            hold_npc_r   <= 32'h0000_0000;
        end else if (capture_s) begin
            hold_instr_r <= iload;
            hold_pc_r    <= pc_in;
            hold_npc_r   <= npc_in;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            ifid_instr_r <= BUBBLE_INSTR;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_npc_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (load_fetch_s) begin
            ifid_instr_r <= iload;
            ifid_pc_r    <= pc_in;
            ifid_npc_r   <= npc_in;
            ifid_valid_r <= 1'b1;
        end else if (load_hold_s) begin
            ifid_instr_r <= hold_instr_r;
            ifid_pc_r    <= hold_pc_r;
            ifid_npc_r   <= hold_npc_r;
            ifid_valid_r <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt_r;
    logic [31:0] perf_bubble_cnt_r;

    // Miss-cycle and bubble counters, free-running with natural wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_cnt_r  <= 32'h0000_0000;
            perf_bubble_cnt_r <= 32'h0000_0000;
        end else begin
            if (state_r == ST_FETCH && !ihit) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end
            if (flush) begin
                perf_bubble_cnt_r <= perf_bubble_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = perf_stall_cnt_r;
    assign perf_bubble_cnt = perf_bubble_cnt_r;
`else
    assign perf_stall_cnt  = 32'h0000_0000;
    assign perf_bubble_cnt = 32'h0000_0000;
`endif

    assign iREN       = iren_s;
    assign iaddr      = pc_in;
    assign fetch_done = fetch_done_s;
    assign ifid_instr = ifid_instr_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_npc   = ifid_npc_r;
    assign ifid_valid = ifid_valid_r;
    assign halted     = (state_r == ST_HALTED);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table plus randomized run against a behavioural model.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] npc_in = 32'h4;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic        fetch_done;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .CLK(CLK), .RST(RST), .pc_in(pc_in), .npc_in(npc_in), .ihit(ihit),
        .iload(iload), .stall(stall), .flush(flush), .iREN(iREN), .iaddr(iaddr),
        .fetch_done(fetch_done), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .halted(halted),
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, ihit, stall, flush;
        logic [31:0] pc, iload;
        logic        e_iren, e_fd;
        logic [31:0] e_instr, e_pc, e_npc;
        logic        e_valid, e_halted;
    } vec_t;

    vec_t tab[26];

    // Behavioural reference: pipeline contents, one pending fetch, halted flag, counters
    logic [31:0] m_instr, m_pc, m_npc;
    logic        m_valid;
    bit          m_halted, m_holding;
    logic [31:0] h_instr, h_pc, h_npc;
    logic [31:0] m_stall_cnt, m_bubble_cnt;

    function automatic vec_t mk(logic r, logic ih, logic st, logic fl, logic [31:0] pc,
                                logic [31:0] ld, logic ir, logic fd, logic [31:0] ins,
                                logic [31:0] p, logic [31:0] np, logic v, logic h);
        vec_t x;
        x.rst = r; x.ihit = ih; x.stall = st; x.flush = fl; x.pc = pc; x.iload = ld;
        x.e_iren = ir; x.e_fd = fd; x.e_instr = ins; x.e_pc = p; x.e_npc = np;
        x.e_valid = v; x.e_halted = h;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (RST) begin
            m_instr = 32'h0; m_pc = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            m_halted = 1'b0; m_holding = 1'b0;
            m_stall_cnt = 32'h0; m_bubble_cnt = 32'h0;
        end else begin
            if (!m_halted && !m_holding && !ihit) m_stall_cnt = m_stall_cnt + 32'd1;
            if (flush) begin
                m_instr = 32'h0; m_pc = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
                m_halted = 1'b0; m_holding = 1'b0;
                m_bubble_cnt = m_bubble_cnt + 32'd1;
            end else if (m_halted) begin
                m_valid = m_valid;
            end else if (m_holding) begin
                if (!stall) begin
                    m_instr = h_instr; m_pc = h_pc; m_npc = h_npc; m_valid = 1'b1;
                    m_holding = 1'b0;
                    m_halted = (h_instr[31:26] == 6'h3F);
                end
            end else if (ihit) begin
                if (stall) begin
                    h_instr = iload; h_pc = pc_in; h_npc = npc_in; m_holding = 1'b1;
                end else begin
                    m_instr = iload; m_pc = pc_in; m_npc = npc_in; m_valid = 1'b1;
                    m_halted = (iload[31:26] == 6'h3F);
                end
            end
        end
    endtask

    // One clock: drive, check request side mid-cycle, clock, check IF/ID side
    task automatic cycle(input vec_t v, input bit use_tab, input string tag);
        logic exp_iren, exp_fd;
        RST = v.rst; ihit = v.ihit; stall = v.stall; flush = v.flush;
        pc_in = v.pc; npc_in = v.pc + 32'd4; iload = v.iload;
        #3;
        exp_iren = !RST && !m_halted && !m_holding;
        exp_fd   = !m_halted && !m_holding && ihit && !flush;
        chk({tag, " iaddr"}, iaddr, pc_in);
        chk({tag, " iREN"}, {31'h0, iREN}, {31'h0, exp_iren});
        if (!RST) chk({tag, " fetch_done"}, {31'h0, fetch_done}, {31'h0, exp_fd});
        if (use_tab) begin
            chk({tag, " tab iREN"}, {31'h0, iREN}, {31'h0, v.e_iren});
            if (!RST) chk({tag, " tab fetch_done"}, {31'h0, fetch_done}, {31'h0, v.e_fd});
        end
        @(posedge CLK);
        model_step();
        #1;
        chk({tag, " ifid_instr"}, ifid_instr, m_instr);
        chk({tag, " ifid_pc"}, ifid_pc, m_pc);
        chk({tag, " ifid_npc"}, ifid_npc, m_npc);
        chk({tag, " ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
        chk({tag, " halted"}, {31'h0, halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_EN
        chk({tag, " perf_stall"}, perf_stall_cnt, m_stall_cnt);
        chk({tag, " perf_bubble"}, perf_bubble_cnt, m_bubble_cnt);
`else
        chk({tag, " perf_stall"}, perf_stall_cnt, 32'h0);
        chk({tag, " perf_bubble"}, perf_bubble_cnt, 32'h0);
`endif
        if (use_tab) begin
            chk({tag, " tab instr"}, ifid_instr, v.e_instr);
            chk({tag, " tab pc"}, ifid_pc, v.e_pc);
            chk({tag, " tab npc"}, ifid_npc, v.e_npc);
            chk({tag, " tab valid"}, {31'h0, ifid_valid}, {31'h0, v.e_valid});
            chk({tag, " tab halted"}, {31'h0, halted}, {31'h0, v.e_halted});
        end
    endtask

    initial begin
        vec_t rv;
        m_instr = 32'h0; m_pc = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
        m_halted = 1'b0; m_holding = 1'b0;
        h_instr = 32'h0; h_pc = 32'h0; h_npc = 32'h0;
        m_stall_cnt = 32'h0; m_bubble_cnt = 32'h0;

        //            rst  ihit stall flush pc           iload         iren fd   instr         pc          npc         v    h
        tab[0]  = mk(1'b1,1'b0,1'b0,1'b0,32'h00,32'h0000_0000, 1'b0,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[1]  = mk(1'b1,1'b0,1'b0,1'b0,32'h00,32'h0000_0000, 1'b0,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[2]  = mk(1'b0,1'b1,1'b0,1'b0,32'h00,32'h2008_0005, 1'b1,1'b1,32'h2008_0005,32'h00,32'h04,1'b1,1'b0);
        tab[3]  = mk(1'b0,1'b0,1'b0,1'b0,32'h10,32'h0000_0000, 1'b1,1'b0,32'h2008_0005,32'h00,32'h04,1'b1,1'b0);
        tab[4]  = mk(1'b0,1'b0,1'b0,1'b0,32'h10,32'h0000_0000, 1'b1,1'b0,32'h2008_0005,32'h00,32'h04,1'b1,1'b0);
        tab[5]  = mk(1'b0,1'b0,1'b0,1'b0,32'h10,32'h0000_0000, 1'b1,1'b0,32'h2008_0005,32'h00,32'h04,1'b1,1'b0);
        tab[6]  = mk(1'b0,1'b1,1'b0,1'b0,32'h10,32'h2409_0010, 1'b1,1'b1,32'h2409_0010,32'h10,32'h14,1'b1,1'b0);
        tab[7]  = mk(1'b0,1'b1,1'b1,1'b0,32'h20,32'h8C09_0000, 1'b1,1'b1,32'h2409_0010,32'h10,32'h14,1'b1,1'b0);
        tab[8]  = mk(1'b0,1'b1,1'b1,1'b0,32'h24,32'h1234_0000, 1'b0,1'b0,32'h2409_0010,32'h10,32'h14,1'b1,1'b0);
        tab[9]  = mk(1'b0,1'b0,1'b1,1'b0,32'h24,32'h0000_0000, 1'b0,1'b0,32'h2409_0010,32'h10,32'h14,1'b1,1'b0);
        tab[10] = mk(1'b0,1'b0,1'b0,1'b0,32'h24,32'h0000_0000, 1'b0,1'b0,32'h8C09_0000,32'h20,32'h24,1'b1,1'b0);
        tab[11] = mk(1'b0,1'b0,1'b0,1'b0,32'h24,32'h0000_0000, 1'b1,1'b0,32'h8C09_0000,32'h20,32'h24,1'b1,1'b0);
        tab[12] = mk(1'b0,1'b1,1'b1,1'b1,32'h24,32'h1234_5678, 1'b1,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[13] = mk(1'b0,1'b1,1'b0,1'b0,32'h30,32'hFFFF_FFFF, 1'b1,1'b1,32'hFFFF_FFFF,32'h30,32'h34,1'b1,1'b1);
        tab[14] = mk(1'b0,1'b1,1'b0,1'b0,32'h34,32'h0000_0000, 1'b0,1'b0,32'hFFFF_FFFF,32'h30,32'h34,1'b1,1'b1);
        tab[15] = mk(1'b0,1'b0,1'b0,1'b0,32'h34,32'h0000_0000, 1'b0,1'b0,32'hFFFF_FFFF,32'h30,32'h34,1'b1,1'b1);
        tab[16] = mk(1'b0,1'b1,1'b0,1'b1,32'h40,32'hFFFF_FFFF, 1'b0,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[17] = mk(1'b0,1'b0,1'b0,1'b0,32'h40,32'h0000_0000, 1'b1,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[18] = mk(1'b0,1'b1,1'b1,1'b0,32'h50,32'h1111_2222, 1'b1,1'b1,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[19] = mk(1'b1,1'b0,1'b1,1'b0,32'h54,32'h0000_0000, 1'b0,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[20] = mk(1'b0,1'b0,1'b0,1'b0,32'h54,32'h0000_0000, 1'b1,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[21] = mk(1'b0,1'b0,1'b0,1'b0,32'h54,32'h0000_0000, 1'b1,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[22] = mk(1'b0,1'b1,1'b1,1'b0,32'h60,32'hFC00_0000, 1'b1,1'b1,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);
        tab[23] = mk(1'b0,1'b0,1'b0,1'b0,32'h64,32'h0000_0000, 1'b0,1'b0,32'hFC00_0000,32'h60,32'h64,1'b1,1'b1);
        tab[24] = mk(1'b0,1'b0,1'b0,1'b0,32'h64,32'h0000_0000, 1'b0,1'b0,32'hFC00_0000,32'h60,32'h64,1'b1,1'b1);
        tab[25] = mk(1'b0,1'b0,1'b0,1'b1,32'h64,32'h0000_0000, 1'b0,1'b0,32'h0000_0000,32'h00,32'h00,1'b0,1'b0);

        for (int i = 0; i < 26; i++) begin
            cycle(tab[i], 1'b1, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 400; n++) begin
            rv = tab[0];
            rv.rst   = ($urandom_range(0, 63) == 0);
            rv.flush = ($urandom_range(0, 9) == 0);
            rv.stall = ($urandom_range(0, 2) == 0);
            rv.ihit  = $urandom_range(0, 1);
            rv.pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rv.iload = $urandom();
            if ($urandom_range(0, 7) == 0) rv.iload[31:26] = 6'h3F;
            cycle(rv, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
